// File: rtl/pipelined_data_memory_bus.sv
// Word-addressed data RAM slave with fixed read latency and a bounded number of
// outstanding reads, flow-controlled through wait_req.
module pipelined_data_memory_bus #(
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int READ_LATENCY   = 2,
    parameter int MAX_PENDING    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    output logic        wait_req,
    output logic        valid,
    output logic [31:0] read_data
);
    localparam int L  = READ_LATENCY;
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic [31:0]               mem [2**MEM_WORDS_LOG2];
    logic [MEM_WORDS_LOG2-1:0] idx;
    logic [PW-1:0]             pending;
    logic                      rd_acc, wr_acc, ret_in;
    logic [L:1]                vld_pipe;
    logic [L:1][31:0]          dat_pipe;
    logic [L:0]                vld_nxt;
    logic [L:0][31:0]          dat_nxt;
    logic                      unused_addr;

    assign idx         = address[MEM_WORDS_LOG2+1:2];
    assign unused_addr = ^{address[31:MEM_WORDS_LOG2+2], address[1:0]};

    assign wait_req = (pending == PW'(MAX_PENDING));
    assign wr_acc   = write_enable && !wait_req;
    // A request with both enables set is treated as a write only.
    assign rd_acc   = read_enable && !write_enable && !wait_req;

    // Element 0 is the RAM word entering the pipe; element L is the output stage.
    assign vld_nxt   = {vld_pipe, rd_acc};
    assign dat_nxt   = {dat_pipe, mem[idx]};
    assign valid     = vld_nxt[L];
    assign read_data = dat_nxt[L];

    // A read stops counting as pending as soon as it enters the output stage,
    // so MAX_PENDING == READ_LATENCY sustains one read per cycle.
    assign ret_in = vld_nxt[L-1];

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_enable[i]) mem[idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
            pending  <= '0;
        end else begin
            vld_pipe <= vld_nxt[L-1:0];
            // Data stages load only with a live read, so the output holds its last word.
            for (int k = 1; k <= L; k++) begin
                if (vld_nxt[k-1]) dat_pipe[k] <= dat_nxt[k-1];
            end
            case ({rd_acc, ret_in})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end
endmodule

// File: tb/tb_pipelined_data_memory_bus.sv
// Bench for pipelined_data_memory_bus: default build plus a MAX_PENDING=1 build
// driven in lockstep and checked against a transaction-level reference model.
module tb_pipelined_data_memory_bus;
    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic        read_enable = 1'b0, write_enable = 1'b0;
    logic [3:0]  byte_enable = '0;
    logic [31:0] write_data = '0;
    logic        wait0, valid0, wait1, valid1;
    logic [31:0] rdata0, rdata1;

    always #5 clock = ~clock;

    pipelined_data_memory_bus u_dut (
        .clock(clock), .reset(reset), .address(address), .read_enable(read_enable),
        .write_enable(write_enable), .byte_enable(byte_enable), .write_data(write_data),
        .wait_req(wait0), .valid(valid0), .read_data(rdata0));

    pipelined_data_memory_bus #(.MAX_PENDING(1)) u_dut_p1 (
        .clock(clock), .reset(reset), .address(address), .read_enable(read_enable),
        .write_enable(write_enable), .byte_enable(byte_enable), .write_data(write_data),
        .wait_req(wait1), .valid(valid1), .read_data(rdata1));

    typedef struct {
        int          k;
        int          t;
        logic [31:0] d;
    } rd_t;

    typedef struct {
        logic        r, w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    rd_t         rq[$];
    logic [31:0] mm [2][1024];
    logic [31:0] last [2];
    int          mp [2] = '{2, 1};
    int          n_cmp = 0, n_bad = 0, cyc_n = 0;
    int          chk_cyc = -1;
    logic [31:0] chk_exp = '0;
    int          nwait0, nwait1, nval0, nval1;
    vec_t        tbl [12];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc_n, act, exp);
        end
    endtask

    // One bus cycle: drive, sample at negedge, compare with the model, advance the model.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        logic        evv;
        logic [31:0] ev;
        int          pend;
        logic        wq, vq;
        logic [31:0] rdq;
        int          wi;
        read_enable  = r;
        write_enable = w;
        address      = a;
        byte_enable  = b;
        write_data   = d;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            wq  = (k == 0) ? wait0  : wait1;
            vq  = (k == 0) ? valid0 : valid1;
            rdq = (k == 0) ? rdata0 : rdata1;
            evv = 1'b0;
            ev  = '0;
            for (int i = rq.size() - 1; i >= 0; i--) begin
                if (rq[i].k == k && rq[i].t == cyc_n) begin
                    evv = 1'b1;
                    ev  = rq[i].d;
                    rq.delete(i);
                end
            end
            if (evv) last[k] = ev;
            pend = 0;
            foreach (rq[i]) if (rq[i].k == k) pend++;
            chk("wait_req", k, {31'd0, wq}, {31'd0, pend == mp[k]});
            chk("valid", k, {31'd0, vq}, {31'd0, evv});
            chk("read_data", k, rdq, last[k]);
            if (pend != mp[k] && (r || w)) begin
                wi = int'(a[11:2]);
                if (w) begin
                    for (int j = 0; j < 4; j++)
                        if (b[j]) mm[k][wi][8*j +: 8] = d[8*j +: 8];
                end else begin
                    rq.push_back('{k: k, t: cyc_n + L, d: mm[k][wi]});
                end
            end
        end
        if (wait0)  nwait0++;
        if (wait1)  nwait1++;
        if (valid0) nval0++;
        if (valid1) nval1++;
        if (cyc_n == chk_cyc) begin
            chk("tbl_valid", 0, {31'd0, valid0}, 32'd1);
            chk("tbl_data", 0, rdata0, chk_exp);
        end
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        read_enable  = 1'b0;
        write_enable = 1'b0;
        reset        = 1'b0;
        rq.delete();
        last = '{32'h0, 32'h0};
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("rst_valid", 0, {31'd0, valid0}, 32'd0);
            chk("rst_data", 0, rdata0, 32'd0);
            chk("rst_wait", 0, {31'd0, wait0}, 32'd0);
            chk("rst_valid", 1, {31'd0, valid1}, 32'd0);
            chk("rst_wait", 1, {31'd0, wait1}, 32'd0);
            @(posedge clock);
            #1;
            cyc_n++;
        end
        reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0,         1'b1, 32'h11BB_33DD};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'h0000_0055, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b1, 32'h0000_0055};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_0003, 4'h0, 32'h0,         1'b1, 32'h0000_0055};
        tbl[9]  = '{1'b1, 1'b1, 32'h0000_0030, 4'hF, 32'h0000_0077, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_0030, 4'h0, 32'h0,         1'b1, 32'h0000_0077};
        tbl[11] = '{1'b1, 1'b0, 32'hFFFF_F010, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF};

        @(posedge clock);
        #1;
        do_reset(3);
        idle(2);

        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b1, 32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i * 32'h1111));
        idle(1);

        foreach (tbl[i]) begin
            if (tbl[i].chk) begin
                chk_cyc = cyc_n + L;
                chk_exp = tbl[i].exp;
            end
            cyc(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].d);
            if (tbl[i].r) idle(2);
        end
        idle(2);

        nwait0 = 0; nwait1 = 0; nval0 = 0; nval1 = 0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);
        idle(4);
        chk("bp_wait_cnt", 0, 32'(nwait0), 32'd0);
        chk("bp_wait_cnt", 1, 32'(nwait1), 32'd3);
        chk("bp_valid_cnt", 0, 32'(nval0), 32'd6);
        chk("bp_valid_cnt", 1, 32'(nval1), 32'd3);

        nval0 = 0; nval1 = 0;
        cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        do_reset(1);
        idle(4);
        chk("flight_valid_cnt", 0, 32'(nval0), 32'd0);
        chk("flight_valid_cnt", 1, 32'(nval1), 32'd0);
        chk_cyc = cyc_n + L;
        chk_exp = 32'hDEAD_BEEF;
        cyc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [31:0] a;
            sel = int'($urandom_range(0, 7));
            a = (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_F000) : 32'h0)
                | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            cyc(sel <= 3, sel >= 4 && sel <= 6, a, 4'($urandom), $urandom);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
